bcd_mod_counter: RTL
====================

Name: bcd_mod_counter

Overview:
- Parametrised successor to the fixed 00-59 clock counter: a multi-digit BCD up/down counter with configurable modulus and minimum value.
- One instance covers seconds/minutes (0-59), 24-hour hours (0-23) and 12-hour hours (1-12).
- Adds a synchronous preset load with range checking, plus separate carry and borrow outputs for chaining.
- Sits in the clock datapath; each stage's o_roll drives the next stage's i_ena.

Parameters:
- DIGITS, 2, number of BCD digits; o_q width is 4*DIGITS.
- MODULUS, 60, number of distinct count states; must be >= 2.
- MIN_VAL, 0, lowest count value in binary; MAX_VAL = MIN_VAL + MODULUS - 1 must be < 10**DIGITS (elaboration-time check, $error on violation).

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_reset_n  in  1  synchronous active-low reset.
- i_ena  in  1  count tick, one clock wide; sampled each rising edge.
- i_inc  in  1  direction: 1 = count up, 0 = count down.
- i_load  in  1  synchronous preset strobe.
- i_load_val  in  4*DIGITS  BCD preset value.
- o_q  out  4*DIGITS  current count, BCD, digit 0 in bits [3:0].
- o_carry  out  1  one-cycle pulse on up-wrap MAX_VAL -> MIN_VAL.
- o_borrow  out  1  one-cycle pulse on down-wrap MIN_VAL -> MAX_VAL.
- o_roll  out  1  o_carry OR o_borrow (registered, not a gate after the flops).
- o_load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset: when i_reset_n = 0 at a rising edge:
  - o_q = MIN_VAL in BCD; o_carry, o_borrow, o_roll, o_load_err = 0.
  - Reset overrides load and count.
- Priority per edge: reset > load > count > hold.
- Load (i_load = 1), i_ena ignored that cycle:
  - Valid when every digit is <= 9 and MIN_VAL <= value <= MAX_VAL. o_q takes i_load_val at the next edge; no carry/borrow.
  - Invalid: o_q holds and o_load_err = 1 for exactly one cycle.
- Count (i_ena = 1, i_load = 0):
  - Up: o_q = MAX_VAL goes to MIN_VAL, o_carry = 1 and o_roll = 1 in the same cycle the wrapped value appears. Otherwise o_q increments by 1.
  - Down: o_q = MIN_VAL goes to MAX_VAL, o_borrow = 1 and o_roll = 1. Otherwise o_q decrements by 1.
- Arithmetic is done per digit in BCD with a ripple carry/borrow chain:
  - Increment: a digit at 9 becomes 0 and carries.
  - Decrement: a digit at 0 becomes 9 and borrows.
  - No binary intermediate; wrap is detected by comparing against the BCD constants MAX_VAL and MIN_VAL.
- Hold (i_ena = 0, i_load = 0): o_q unchanged; all pulse outputs 0.
- Pulse outputs are registered and high for exactly one clock. With i_ena held high across consecutive wraps (MODULUS = 2), o_roll re-pulses on every wrap.
- Latency: one clock from a sampled i_ena/i_load to the o_q update.
- i_inc is sampled only when i_ena = 1; changing it between ticks has no effect.
- Reset asserted mid-operation (e.g. on the edge where a wrap would occur): o_q = MIN_VAL, and o_carry/o_borrow/o_roll = 0 that cycle.
- Out-of-range state is unreachable: reset and load are the only entries, and load is checked.

Test Plan:
- Defaults (60,0), reset, 60 up-ticks: o_q steps 00..59 then 00. o_carry and o_roll pulse exactly once, with o_q = 8'h00. No pulse elsewhere.
- Defaults, reset, 1 down-tick: o_q = 8'h59 with o_borrow = 1 and o_roll = 1 for one cycle. Next down-tick gives 8'h58 and no pulse.
- MODULUS = 12, MIN_VAL = 1:
  - Load 8'h12 then up-tick: o_q = 8'h01 with o_carry pulse.
  - Down-tick from 8'h01: o_q = 8'h12 with o_borrow pulse.
  - Load 8'h00, 8'h13 or 8'h1A: o_q unchanged, o_load_err pulses once per attempt.
- Defaults, o_q = 8'h59: drive i_load = 1 with 8'h30 and i_ena = 1 on the same edge. o_q = 8'h30, no carry. Then assert i_reset_n = 0 while i_ena = 1: o_q = 8'h00, o_roll = 0.
- MODULUS = 24, DIGITS = 2: count up from 8'h09 -> 8'h10 (digit carry, no o_roll), and 8'h19 -> 8'h20. From 8'h23, up-tick gives 8'h00 with o_roll.
- Chain two instances, (60,0) feeding (24,0) via o_roll -> i_ena: 1440 ticks on the first stage return both stages to 00 with exactly 24 first-stage rolls and 1 second-stage roll.

Source files
------------

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD up/down counter with programmable modulus and floor value,
// synchronous preset load with range checking, and registered wrap pulses.
module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60,
  parameter int MIN_VAL = 0
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_ena,
  input  logic                i_inc,
  input  logic                i_load,
  input  logic [4*DIGITS-1:0] i_load_val,
  output logic [4*DIGITS-1:0] o_q,
  output logic                o_carry,
  output logic                o_borrow,
  output logic                o_roll,
  output logic                o_load_err
);

  localparam int W       = 4 * DIGITS;
  localparam int MAX_VAL = MIN_VAL + MODULUS - 1;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int k = 0; k < n; k++) begin
      r = r * 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = {W{1'b0}};
    t = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t           = t / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VAL);
  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

  if (MODULUS < 2 || MIN_VAL < 0 || MAX_VAL >= pow10(DIGITS)) begin : g_param_check
    $error("bcd_mod_counter: MODULUS must be >= 2 and MIN_VAL..MAX_VAL must fit in DIGITS BCD digits");
  end

  logic [W-1:0] r_q;
  logic         r_carry;
  logic         r_borrow;
  logic         r_roll;
  logic         r_load_err;

  logic [W-1:0] w_inc_q;
  logic [W-1:0] w_dec_q;
  logic [W-1:0] w_q_next;
  logic         w_digits_ok;
  logic         w_ge_min;
  logic         w_load_ok;
  logic         w_carry_next;
  logic         w_borrow_next;
  logic         w_err_next;

  // With a valid-digit BCD value, unsigned vector order equals numeric order.
  if (MIN_VAL == 0) begin : g_ge_min_zero
    assign w_ge_min = 1'b1;
  end else begin : g_ge_min_cmp
    assign w_ge_min = (i_load_val >= MIN_BCD);
  end

  assign w_load_ok = w_digits_ok && w_ge_min && (i_load_val <= MAX_BCD);

  // Per-digit BCD increment/decrement ripple and load digit validation.
  always_comb begin
    logic       w_c;
    logic       w_b;
    logic [3:0] w_dig;
    w_c         = 1'b1;
    w_b         = 1'b1;
    w_digits_ok = 1'b1;
    w_inc_q     = r_q;
    w_dec_q     = r_q;
    for (int d = 0; d < DIGITS; d++) begin
      w_dig = r_q[4*d +: 4];
      if (w_c) begin
        if (w_dig == 4'd9) begin
          w_inc_q[4*d +: 4] = 4'd0;
        end else begin
          w_inc_q[4*d +: 4] = w_dig + 4'd1;
        end
      end else begin
        w_inc_q[4*d +: 4] = w_dig;
      end
      if (w_b) begin
        if (w_dig == 4'd0) begin
          w_dec_q[4*d +: 4] = 4'd9;
        end else begin
          w_dec_q[4*d +: 4] = w_dig - 4'd1;
        end
      end else begin
        w_dec_q[4*d +: 4] = w_dig;
      end
      w_c = w_c & (w_dig == 4'd9);
      w_b = w_b & (w_dig == 4'd0);
      if (i_load_val[4*d +: 4] > 4'd9) begin
        w_digits_ok = 1'b0;
      end else begin
        w_digits_ok = w_digits_ok;
      end
    end
  end

  // Next count and pulse selection: load beats count beats hold.
  always_comb begin
    w_q_next      = r_q;
    w_carry_next  = 1'b0;
    w_borrow_next = 1'b0;
    w_err_next    = 1'b0;
    if (i_load) begin
      if (w_load_ok) begin
        w_q_next = i_load_val;
      end else begin
        w_err_next = 1'b1;
      end
    end else if (i_ena) begin
      if (i_inc) begin
        if (r_q == MAX_BCD) begin
          w_q_next     = MIN_BCD;
          w_carry_next = 1'b1;
        end else begin
          w_q_next = w_inc_q;
        end
      end else begin
        if (r_q == MIN_BCD) begin
          w_q_next      = MAX_BCD;
          w_borrow_next = 1'b1;
        end else begin
          w_q_next = w_dec_q;
        end
      end
    end else begin
      w_q_next = r_q;
    end
  end

  // Count register and pulse flops; reset overrides load and count.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_q        <= MIN_BCD;
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_roll     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_q        <= w_q_next;
      r_carry    <= w_carry_next;
      r_borrow   <= w_borrow_next;
      r_roll     <= w_carry_next | w_borrow_next;
      r_load_err <= w_err_next;
    end
  end

  assign o_q        = r_q;
  assign o_carry    = r_carry;
  assign o_borrow   = r_borrow;
  assign o_roll     = r_roll;
  assign o_load_err = r_load_err;

endmodule
